// File: rtl/alu_issue.sv
// Single-issue RISC-V R-type ALU sequencer: IDLE/READ/EXEC/WB over a 32 x N register file with preload and debug ports.
// Optional macro ALU_ISSUE_ILLEGAL_EN adds a one-cycle `illegal` pulse for unsupported encodings.
module alu_issue #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_r,
  input  logic         ld_en,
  input  logic [4:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  input  logic [4:0]   dbg_addr,
  output logic [N-1:0] dbg_data,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [N-1:0] wb_data
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic         illegal
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state;
  logic [31:0] ir;
  logic [N-1:0] res;
  logic [N-1:0] rf [32];

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic       dec_ok;
  logic [2:0] dec_op;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign instr_ready = (state == IDLE);
  assign dbg_data    = rf[dbg_addr];

  always_comb begin
    dec_ok = 1'b0;
    dec_op = 3'd0;
    if (opcode == 7'b0110011) begin
      case ({f7, f3})
        {7'b0000000, 3'b000}: begin dec_ok = 1'b1; dec_op = 3'd0; end
        {7'b0100000, 3'b000}: begin dec_ok = 1'b1; dec_op = 3'd1; end
        {7'b0000000, 3'b111}: begin dec_ok = 1'b1; dec_op = 3'd2; end
        {7'b0000000, 3'b110}: begin dec_ok = 1'b1; dec_op = 3'd3; end
        {7'b0000000, 3'b100}: begin dec_ok = 1'b1; dec_op = 3'd4; end
        default: begin dec_ok = 1'b0; dec_op = 3'd0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      res      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal  <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= READ;
          end
        end
        READ: begin
          alu_a  <= rf[rs1];
          alu_b  <= rf[rs2];
          alu_op <= dec_op;
          state  <= dec_ok ? EXEC : IDLE;
`ifdef ALU_ISSUE_ILLEGAL_EN
          illegal <= !dec_ok;
`endif
        end
        EXEC: begin
          res   <= alu_r;
          state <= WB;
        end
        WB: begin
          wb_valid <= 1'b1;
          wb_rd    <= rd;
          wb_data  <= res;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back is ordered after the preload so it wins a same-address collision; x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (ld_en && ld_addr != 5'd0) rf[ld_addr] <= ld_data;
      if (state == WB && rd != 5'd0) rf[rd] <= res;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected write-backs are queued at issue and popped by a write-back monitor.
module tb_alu_issue;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [N-1:0] alu_a, alu_b, alu_r;
  logic [2:0]   alu_op;
  logic         ld_en;
  logic [4:0]   ld_addr;
  logic [N-1:0] ld_data;
  logic [4:0]   dbg_addr;
  logic [N-1:0] dbg_data;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic         illegal;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  alu_issue #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef ALU_ISSUE_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  // External combinational ALU the block drives.
  always_comb begin
    case (alu_op)
      3'd0: alu_r = alu_a + alu_b;
      3'd1: alu_r = alu_a - alu_b;
      3'd2: alu_r = alu_a & alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = alu_a ^ alu_b;
      default: alu_r = '0;
    endcase
  end

  task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  always @(negedge clk) begin
    wb_t e;
    if (rst_n && wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wb_rd", wb_rd, e.rd);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [N-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic rf_check(input string tag, input logic [4:0] a, input logic [N-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic issue(input logic [31:0] w, input bit exp_wb, input logic [2:0] exp_op,
                       input logic [4:0] erd, input logic [N-1:0] edat,
                       input bit do_ld, input logic [4:0] la, input logic [N-1:0] ldd);
    int waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr = w;
    if (exp_wb) sb.push_back('{erd, edat});
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom();
    @(negedge clk);
    check("busy_in_read", instr_ready, 0);
    check("wb_early0", wb_valid, 0);
    @(negedge clk);
    if (exp_wb) check("alu_op", alu_op, exp_op);
    else        check("ready_after_bad", instr_ready, 1);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("illegal", illegal, !exp_wb);
`endif
    check("wb_early1", wb_valid, 0);
    @(negedge clk);
    check("wb_early2", wb_valid, 0);
    if (do_ld) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
    end
    @(negedge clk);
    ld_en = 1'b0;
    check("wb_latency", wb_valid, exp_wb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb, ex;
    logic [2:0]   op;
    logic [4:0]   rdr;
    logic [31:0]  w;

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_wb_data", wb_data, 0);
    rst_n = 1'b1;

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue(32'h002081B3, 1, 3'd0, 5'd3, 32'd8, 0, 5'd0, '0);
    rf_check("dbg_x3_add", 5'd3, 32'd8);
    issue(32'h40208233, 1, 3'd1, 5'd4, 32'd2, 0, 5'd0, '0);
    issue(32'h40110233, 1, 3'd1, 5'd4, 32'hFFFFFFFE, 0, 5'd0, '0);
    rf_check("dbg_x4_sub", 5'd4, 32'hFFFFFFFE);

    preload(5'd1, 32'hF0F0F0F0);
    preload(5'd2, 32'hFF00FF00);
    issue(rtype(7'b0, 5'd2, 5'd1, 3'b111, 5'd5), 1, 3'd2, 5'd5, 32'hF000F000, 0, 5'd0, '0);
    issue(rtype(7'b0, 5'd2, 5'd1, 3'b110, 5'd5), 1, 3'd3, 5'd5, 32'hFFF0FFF0, 0, 5'd0, '0);
    issue(rtype(7'b0, 5'd2, 5'd1, 3'b100, 5'd5), 1, 3'd4, 5'd5, 32'h0FF00FF0, 0, 5'd0, '0);
    rf_check("dbg_x5_xor", 5'd5, 32'h0FF00FF0);
    issue(rtype(7'b0, 5'd2, 5'd1, 3'b100, 5'd0), 1, 3'd4, 5'd0, 32'h0FF00FF0, 0, 5'd0, '0);
    rf_check("dbg_x0", 5'd0, 32'd0);

    issue(32'h00108093, 0, 3'd0, 5'd0, '0, 0, 5'd0, '0);
    issue(rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd6), 0, 3'd0, 5'd0, '0, 0, 5'd0, '0);
    rf_check("dbg_x6_untouched", 5'd6, 32'd0);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue(32'h002081B3, 1, 3'd0, 5'd3, 32'd8, 1, 5'd3, 32'd7);
    rf_check("collide_same", 5'd3, 32'd8);
    issue(32'h002081B3, 1, 3'd0, 5'd3, 32'd8, 1, 5'd6, 32'd9);
    rf_check("collide_diff_rd", 5'd3, 32'd8);
    rf_check("collide_diff_ld", 5'd6, 32'd9);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom(); rb = $urandom();
      op = 3'($urandom_range(0, 4));
      rdr = 5'($urandom_range(12, 31));
      preload(5'd10, ra);
      preload(5'd11, rb);
      case (op)
        3'd0: begin ex = ra + rb; w = rtype(7'b0000000, 5'd11, 5'd10, 3'b000, rdr); end
        3'd1: begin ex = ra - rb; w = rtype(7'b0100000, 5'd11, 5'd10, 3'b000, rdr); end
        3'd2: begin ex = ra & rb; w = rtype(7'b0000000, 5'd11, 5'd10, 3'b111, rdr); end
        3'd3: begin ex = ra | rb; w = rtype(7'b0000000, 5'd11, 5'd10, 3'b110, rdr); end
        default: begin ex = ra ^ rb; w = rtype(7'b0000000, 5'd11, 5'd10, 3'b100, rdr); end
      endcase
      issue(w, 1, op, rdr, ex, 0, 5'd0, '0);
      rf_check("rand_rf", rdr, ex);
    end

    // Reset while the add sits in EXEC: nothing may be written back.
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_wb_rd", wb_rd, 0);
    check("mid_rst_wb_data", wb_data, 0);
    rf_check("mid_rst_rf_x1", 5'd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    rf_check("post_rst_x3", 5'd3, 32'd0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
